intra_ref_buffer: RTL and testbench

//  Parametrised neighbour-reference buffer for the intra-prediction engine; generalises the fixed 8-pixel top buffer.

---
 rtl/intra_pkg.sv | 25 ++
 rtl/intra_ref_buffer_ref_fill_ctrl.sv | 125 ++++++++++++
 rtl/intra_ref_buffer.sv | 92 +++++++++
 tb/tb_intra_ref_buffer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/intra_pkg.sv
// Shared definitions for the intra-prediction reference buffer.
//   - FSM state encoding for the neighbour-fill controller
//   - mid-grey pad value and slot-counter width helpers
package intra_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LD_TOP  = 3'd1;
    localparam logic [2:0] ST_LD_TR   = 3'd2;
    localparam logic [2:0] ST_LD_LEFT = 3'd3;
    localparam logic [2:0] ST_PAD     = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    // Value used for unavailable neighbours: half of full scale.
    function automatic int mid_grey(input int pix_w);
        return 1 << (pix_w - 1);
    endfunction

    // Slot counter must index the larger of the half top row and the left column.
    function automatic int cnt_width(input int n_half, input int n_left);
        int m;
        m = (n_half > n_left) ? n_half : n_left;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/intra_ref_buffer_ref_fill_ctrl.sv
// Fill sequencer for the reference buffer: walks the available neighbour
// groups in stream order, counts pixels within a group and issues the
// single-cycle pad strobes before flagging the set as valid.
// Ports:
//   CLK, RST_n                      clock, async active-low reset
//   start                           begin a new set (only honoured in IDLE/DONE)
//   top_avail, tr_avail, left_avail availability, latched on an honoured start
//   in_valid / in_ready             pixel handshake (in_ready is registered)
//   wr_top, wr_tr, wr_left          write strobe for the group being loaded
//   wr_idx                          slot within that group
//   pad_top, pad_tr, pad_left       pad strobes, asserted in the PAD cycle only
//   ref_valid                       set complete (DONE state)
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | no set loaded since reset
// ST_LD_TOP  | receiving top pixels 0..N_TOP/2-1
// ST_LD_TR   | receiving top-right pixels (top row upper half)
// ST_LD_LEFT | receiving left column pixels
// ST_PAD     | one cycle: fill unavailable slots
// ST_DONE    | reference set stable, ref_valid high
module ref_fill_ctrl
    import intra_pkg::*;
#(
    parameter int N_TOP  = 8,
    parameter int N_LEFT = 4,
    parameter int CNT_W  = 2
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             start,
    input  logic             top_avail,
    input  logic             tr_avail,
    input  logic             left_avail,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             wr_top,
    output logic             wr_tr,
    output logic             wr_left,
    output logic [CNT_W-1:0] wr_idx,
    output logic             pad_top,
    output logic             pad_tr,
    output logic             pad_left,
    output logic             ref_valid
);

    localparam logic [CNT_W-1:0] LAST_HALF = CNT_W'(N_TOP / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_LEFT = CNT_W'(N_LEFT - 1);

    logic [2:0]       state;
    logic [2:0]       nxt;
    logic [CNT_W-1:0] cnt;
    logic             top_l;
    logic             tr_l;
    logic             left_l;
    logic             launch;
    logic             fire;
    logic             last;

    assign launch = start && (state == ST_IDLE || state == ST_DONE);
    assign fire   = in_valid && in_ready;
    assign last   = (state == ST_LD_LEFT) ? (cnt == LAST_LEFT) : (cnt == LAST_HALF);

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (top_avail)       nxt = ST_LD_TOP;
                    else if (left_avail) nxt = ST_LD_LEFT;
                    else                 nxt = ST_PAD;
                end
            end
            ST_LD_TOP: begin
                if (fire && last) begin
                    if (tr_l)        nxt = ST_LD_TR;
                    else if (left_l) nxt = ST_LD_LEFT;
                    else             nxt = ST_PAD;
                end
            end
            ST_LD_TR: begin
                if (fire && last) nxt = left_l ? ST_LD_LEFT : ST_PAD;
            end
            ST_LD_LEFT: begin
                if (fire && last) nxt = ST_PAD;
            end
            ST_PAD:  nxt = ST_DONE;
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            top_l     <= 1'b0;
            tr_l      <= 1'b0;
            left_l    <= 1'b0;
            in_ready  <= 1'b0;
            ref_valid <= 1'b0;
        end else begin
            state     <= nxt;
            // Registered from the next state so the port is a clean flop output.
            in_ready  <= (nxt == ST_LD_TOP) || (nxt == ST_LD_TR) || (nxt == ST_LD_LEFT);
            ref_valid <= (nxt == ST_DONE);
            if (launch) begin
                top_l  <= top_avail;
                tr_l   <= top_avail && tr_avail;
                left_l <= left_avail;
                cnt    <= '0;
            end else if (fire) begin
                cnt <= last ? '0 : cnt + 1'b1;
            end
        end
    end

    assign wr_top   = fire && (state == ST_LD_TOP);
    assign wr_tr    = fire && (state == ST_LD_TR);
    assign wr_left  = fire && (state == ST_LD_LEFT);
    assign wr_idx   = cnt;
    assign pad_top  = (state == ST_PAD) && !top_l;
    assign pad_tr   = (state == ST_PAD) && top_l && !tr_l;
    assign pad_left = (state == ST_PAD) && !left_l;

endmodule

// File: rtl/intra_ref_buffer.sv
// Neighbour-reference buffer for intra prediction. Pixels for the top,
// top-right and left neighbours stream in over a valid/ready port, land in
// registers, and unavailable groups are padded before ref_valid is raised.
// Ports:
//   CLK, RST_n                      clock, async active-low reset
//   start                           begin loading a new reference set
//   top_avail, tr_avail, left_avail neighbour availability (sampled on start)
//   in_valid, in_ready, in_data     pixel stream handshake and data
//   ref_top                         top row, pixel i at [i*PIX_W +: PIX_W]
//   ref_left                        left column, pixel j at [j*PIX_W +: PIX_W]
//   ref_valid                       reference set complete and stable
module intra_ref_buffer
    import intra_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int N_TOP  = 8,
    parameter int N_LEFT = 4
) (
    input  logic                    CLK,
    input  logic                    RST_n,
    input  logic                    start,
    input  logic                    top_avail,
    input  logic                    tr_avail,
    input  logic                    left_avail,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PIX_W-1:0]        in_data,
    output logic [N_TOP*PIX_W-1:0]  ref_top,
    output logic [N_LEFT*PIX_W-1:0] ref_left,
    output logic                    ref_valid
);

    localparam int               HALF  = N_TOP / 2;
    localparam int               CNT_W = cnt_width(N_TOP / 2, N_LEFT);
    localparam logic [PIX_W-1:0] GREY  = PIX_W'(mid_grey(PIX_W));

    logic             wr_top;
    logic             wr_tr;
    logic             wr_left;
    logic [CNT_W-1:0] wr_idx;
    logic             pad_top;
    logic             pad_tr;
    logic             pad_left;

    ref_fill_ctrl #(
        .N_TOP  (N_TOP),
        .N_LEFT (N_LEFT),
        .CNT_W  (CNT_W)
    ) u_ctrl (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .start      (start),
        .top_avail  (top_avail),
        .tr_avail   (tr_avail),
        .left_avail (left_avail),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wr_top     (wr_top),
        .wr_tr      (wr_tr),
        .wr_left    (wr_left),
        .wr_idx     (wr_idx),
        .pad_top    (pad_top),
        .pad_tr     (pad_tr),
        .pad_left   (pad_left),
        .ref_valid  (ref_valid)
    );

    // Writes and pads never coincide: pads only fire in the PAD cycle,
    // when in_ready is low.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            ref_top  <= '0;
            ref_left <= '0;
        end else begin
            if (wr_top)  ref_top[int'(wr_idx) * PIX_W +: PIX_W]          <= in_data;
            if (wr_tr)   ref_top[(HALF + int'(wr_idx)) * PIX_W +: PIX_W] <= in_data;
            if (wr_left) ref_left[int'(wr_idx) * PIX_W +: PIX_W]         <= in_data;
            if (pad_top) begin
                for (int i = 0; i < N_TOP; i++) ref_top[i * PIX_W +: PIX_W] <= GREY;
            end
            // Missing top-right repeats the last real top pixel.
            if (pad_tr) begin
                for (int i = HALF; i < N_TOP; i++)
                    ref_top[i * PIX_W +: PIX_W] <= ref_top[(HALF - 1) * PIX_W +: PIX_W];
            end
            if (pad_left) begin
                for (int j = 0; j < N_LEFT; j++) ref_left[j * PIX_W +: PIX_W] <= GREY;
            end
        end
    end

endmodule

// File: tb/tb_intra_ref_buffer.sv
module tb_intra_ref_buffer;

    localparam int PW = 8;
    localparam int NT = 8;
    localparam int NL = 4;
    localparam int H  = NT / 2;

    logic CLK = 1'b0;
    logic RST_n = 1'b0;
    always #5 CLK = ~CLK;

    // default-parameter instance
    logic           start = 0, top_avail = 0, tr_avail = 0, left_avail = 0, in_valid = 0;
    logic           in_ready, ref_valid;
    logic [PW-1:0]  in_data = '0;
    logic [NT*PW-1:0] ref_top;
    logic [NL*PW-1:0] ref_left;

    // wide instance: PIX_W=10, N_TOP=16, N_LEFT=8
    logic           start1 = 0, top_avail1 = 0, tr_avail1 = 0, left_avail1 = 0, in_valid1 = 0;
    logic           in_ready1, ref_valid1;
    logic [9:0]     in_data1 = '0;
    logic [159:0]   ref_top1;
    logic [79:0]    ref_left1;

    intra_ref_buffer #(.PIX_W(PW), .N_TOP(NT), .N_LEFT(NL)) dut (
        .CLK(CLK), .RST_n(RST_n), .start(start), .top_avail(top_avail),
        .tr_avail(tr_avail), .left_avail(left_avail), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .ref_top(ref_top),
        .ref_left(ref_left), .ref_valid(ref_valid)
    );

    intra_ref_buffer #(.PIX_W(10), .N_TOP(16), .N_LEFT(8)) dut_w (
        .CLK(CLK), .RST_n(RST_n), .start(start1), .top_avail(top_avail1),
        .tr_avail(tr_avail1), .left_avail(left_avail1), .in_valid(in_valid1),
        .in_ready(in_ready1), .in_data(in_data1), .ref_top(ref_top1),
        .ref_left(ref_left1), .ref_valid(ref_valid1)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [NT*PW-1:0] top;
        logic [NL*PW-1:0] left;
        int               rise;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare each newly presented reference set with the scoreboard head.
    logic pv = 1'b0;
    exp_t e;
    always @(negedge CLK) begin
        if (ref_valid && !pv) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ref_valid actual=1 required=0");
            end else begin
                e = q.pop_front();
                chk("ref_top", ref_top, e.top);
                chk("ref_left", ref_left, e.left);
                chk("valid_cycle", cyc, e.rise);
            end
        end
        pv = ref_valid;
    end

    // Reference model: the set a predictor should see for given flags and stream.
    function automatic void model(input bit t, input bit tr, input bit l,
                                  input logic [PW-1:0] px [12],
                                  output logic [NT*PW-1:0] top, output logic [NL*PW-1:0] left);
        logic [PW-1:0] a [NT];
        int k;
        k = 0;
        for (int i = 0; i < H; i++) begin
            if (t) begin a[i] = px[k]; k++; end
            else a[i] = 8'd128;
        end
        for (int i = H; i < NT; i++) begin
            if (t && tr) begin a[i] = px[k]; k++; end
            else if (t) a[i] = a[H-1];
            else a[i] = 8'd128;
        end
        for (int i = 0; i < NT; i++) top[i*PW +: PW] = a[i];
        for (int j = 0; j < NL; j++) begin
            if (l) begin left[j*PW +: PW] = px[k]; k++; end
            else left[j*PW +: PW] = 8'd128;
        end
    endfunction

    // vmode: 0 valid held, 1 toggling, 2 random. mid_at: inject a start at that
    // pixel count (-1 none). abort_at: stop after that many accepts, no push.
    task automatic load(input bit t, input bit tr, input bit l, input logic [PW-1:0] px [12],
                        input int vmode, input int mid_at, input int abort_at);
        int n, k, acc, budget, s;
        bit sent_mid;
        exp_t x;
        n = (t ? H : 0) + ((t && tr) ? H : 0) + (l ? NL : 0);
        k = 0; acc = 0; budget = 0; sent_mid = 0;
        model(t, tr, l, px, x.top, x.left);
        @(posedge CLK); #1;
        start = 1; top_avail = t; tr_avail = tr; left_avail = l; in_valid = 0;
        @(negedge CLK);
        s = cyc;
        @(posedge CLK); #1;
        start = 0;
        top_avail = 1'($urandom); tr_avail = 1'($urandom); left_avail = 1'($urandom);
        @(negedge CLK);
        chk("valid_drop_after_start", ref_valid, 0);
        if (n == 0) begin
            x.rise = s + 2;
            q.push_back(x);
            for (int i = 0; i < 3; i++) begin
                chk("ready_no_groups", in_ready, 0);
                @(negedge CLK);
            end
        end else begin
            while (k < n && budget < 200) begin
                @(posedge CLK); #1;
                case (vmode)
                    0:       in_valid = 1;
                    1:       in_valid = (budget % 2 == 0);
                    default: in_valid = 1'($urandom);
                endcase
                in_data = in_valid ? px[k] : 8'($urandom);
                start = 0;
                if (mid_at == k && !sent_mid) begin
                    start = 1; sent_mid = 1;
                    top_avail = 1'($urandom); tr_avail = 1'($urandom); left_avail = 1'($urandom);
                end
                @(negedge CLK);
                if (in_valid && in_ready) begin k++; acc = cyc; end
                budget++;
                if (abort_at >= 0 && k == abort_at) break;
            end
            @(posedge CLK); #1;
            in_valid = 0; start = 0;
            if (abort_at >= 0) return;
            checks++;
            if (k < n) begin
                failures++;
                $display("FAIL stream_timeout actual=%0d required=%0d", k, n);
            end else begin
                x.rise = acc + 2;
                q.push_back(x);
            end
        end
        for (int b = 0; b < 20 && q.size() != 0; b++) @(negedge CLK);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL ref_valid_timeout actual=pending%0d required=0", q.size());
            q.delete();
        end
    endtask

    initial begin
        logic [PW-1:0] px [12];
        logic [9:0]    pw [16];
        logic [159:0]  et1;
        int            b;
        bit            t, tr, l;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ref_top", ref_top, 0);
        chk("rst_ref_left", ref_left, 0);
        chk("rst_ref_valid", ref_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        @(posedge CLK); #1;
        RST_n = 1;

        for (int i = 0; i < 12; i++) px[i] = 8'(10 + i);
        load(1, 1, 1, px, 0, -1, -1);

        px = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd50, 8'd51, 8'd52, 8'd53, 8'd0, 8'd0, 8'd0, 8'd0};
        load(1, 0, 1, px, 0, -1, -1);

        load(0, 1, 0, px, 0, -1, -1);

        for (int i = 0; i < 12; i++) px[i] = 8'($urandom);
        load(1, 1, 1, px, 1, 5, -1);

        // async reset in the middle of a top load
        for (int i = 0; i < 12; i++) px[i] = 8'($urandom);
        load(1, 1, 1, px, 0, -1, 3);
        #3 RST_n = 0;
        #1;
        chk("midrst_ref_top", ref_top, 0);
        chk("midrst_ref_left", ref_left, 0);
        chk("midrst_ref_valid", ref_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        @(posedge CLK); #1;
        RST_n = 1;
        for (int i = 0; i < 12; i++) px[i] = 8'($urandom);
        load(1, 1, 1, px, 0, -1, -1);

        for (int r = 0; r < 24; r++) begin
            t = 1'($urandom); tr = 1'($urandom); l = 1'($urandom);
            for (int i = 0; i < 12; i++) px[i] = 8'($urandom);
            load(t, tr, l, px, 2, (r % 3 == 0) ? 2 : -1, -1);
        end

        // wide instance: left unavailable
        for (int i = 0; i < 16; i++) pw[i] = 10'($urandom);
        for (int i = 0; i < 16; i++) et1[i*10 +: 10] = pw[i];
        @(posedge CLK); #1;
        start1 = 1; top_avail1 = 1; tr_avail1 = 1; left_avail1 = 0;
        @(posedge CLK); #1;
        start1 = 0;
        for (int k = 0, g = 0; k < 16 && g < 100; g++) begin
            in_valid1 = 1; in_data1 = pw[k];
            @(negedge CLK);
            if (in_ready1) k++;
            @(posedge CLK); #1;
        end
        in_valid1 = 0;
        b = 0;
        while (!ref_valid1 && b < 10) begin @(negedge CLK); b++; end
        chk("w_ref_valid", ref_valid1, 1);
        chk("w_ref_top", ref_top1, et1);
        chk("w_ref_left", ref_left1, {8{10'd512}});
        @(posedge CLK); #1;
        start1 = 1;
        @(negedge CLK);
        chk("w_valid_before_drop", ref_valid1, 1);
        @(posedge CLK); #1;
        start1 = 0;
        @(negedge CLK);
        chk("w_valid_drop", ref_valid1, 0);

        repeat (2) @(negedge CLK);
        chk("scoreboard_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
